sao_param_resolve: RTL and testbench

//  Decoder-side SAO parameter reconstruction; the receive end of the SAO merge/new parameter stream.

---
 rtl/sao_pkg.sv | 72 +++++++
 rtl/sao_param_linebuf.sv | 38 +++
 rtl/sao_param_resolve.sv | 258 +++++++++++++++++++++++++
 tb/tb_sao_param_resolve.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sao_pkg.sv
// ---------------------------------------------------------------------------
// sao_pkg
//  Shared types and constants for the SAO parameter reconstruction path.
//  - sao_param_t   : one component's SAO parameter set {mode, type, aux, offsets}
//  - SAO_MODE_*    : mode encodings (MERGE exists on the syntax side only)
//  - sao_pack/unpack : conversion to/from the DW-bit line-buffer entry
//                      {mode[1:0], type[2:0], aux[4:0], off0, off1, off2, off3}
//  - sao_comp_base : line-buffer base address of a colour component
//  - state_t       : resolver FSM states
// ---------------------------------------------------------------------------
package sao_pkg;

   localparam int OFFSET_LEN   = 4;
   localparam int N_OFFSET     = 4;
   localparam int N_SAO_TYPE   = 3;
   localparam int AUX_LEN      = 5;
   localparam int MODE_LEN     = 2;
   localparam int N_COMP       = 3;
   localparam int CTU_X_LEN    = 9;
   localparam int CTU_Y_LEN    = 9;
   localparam int MAX_CTU_COLS = 120;
   localparam int AW           = 9;
   localparam int DW           = 26;

   localparam logic [MODE_LEN-1:0] SAO_MODE_OFF   = 2'd0;
   localparam logic [MODE_LEN-1:0] SAO_MODE_NEW   = 2'd1;
   localparam logic [MODE_LEN-1:0] SAO_MODE_MERGE = 2'd2;
   localparam int                  SAO_TYPE_BO_BIT = 2;

   typedef struct packed {
      logic [MODE_LEN-1:0]                   mode;
      logic [N_SAO_TYPE-1:0]                 sao_type;
      logic [AUX_LEN-1:0]                    aux;
      logic [N_OFFSET-1:0][OFFSET_LEN-1:0]   offset;
   } sao_param_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_RESOLVE,
      ST_WRITE,
      ST_OUT
   } state_t;

   // Entry layout places off0 in the most significant offset nibble.
   function automatic logic [DW-1:0] sao_pack(input sao_param_t p);
      return {p.mode, p.sao_type, p.aux,
              p.offset[0], p.offset[1], p.offset[2], p.offset[3]};
   endfunction

   function automatic sao_param_t sao_unpack(input logic [DW-1:0] d);
      sao_param_t p;
      p.mode      = d[25:24];
      p.sao_type  = d[23:21];
      p.aux       = d[20:16];
      p.offset[0] = d[15:12];
      p.offset[1] = d[11:8];
      p.offset[2] = d[7:4];
      p.offset[3] = d[3:0];
      return p;
   endfunction

   // Each component owns a contiguous MAX_CTU_COLS slice of the line buffer.
   function automatic logic [AW-1:0] sao_comp_base(input logic [1:0] c_idx);
      case (c_idx)
         2'd1:    return AW'(MAX_CTU_COLS);
         2'd2:    return AW'(2 * MAX_CTU_COLS);
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/sao_param_linebuf.sv
// ---------------------------------------------------------------------------
// sao_param_linebuf
//  Single-port synchronous RAM holding the resolved SAO parameters of the
//  CTU row above. One-cycle registered read; contents are not reset.
//  Ports:
//   clk    in   clock
//   en     in   access enable
//   we     in   write enable (read when en && !we)
//   addr   in   AW-bit address
//   wdata  in   DW-bit write data
//   rdata  out  DW-bit read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module sao_param_linebuf #(
   parameter int DEPTH = 360,
   parameter int DW    = 26,
   parameter int AW    = 9
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/sao_param_resolve.sv
// ---------------------------------------------------------------------------
// sao_param_resolve
//  Decoder-side SAO parameter reconstruction. Accepts one CTU's parsed SAO
//  syntax, resolves merge_left / merge_up against the left-CTU registers and
//  the upper-row line buffer, writes the result back to both, and presents
//  it to the SAO filter with a valid/ready handshake.
//  Optional feature macro: SAO_MERGE_CHK_EN (illegal-merge detection).
//  Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       CTU syntax handshake (in_ready = idle)
//   in_ctu_x, in_ctu_y        CTU position
//   in_merge_left/up          merge flags (merge_left wins)
//   in_mode/type/aux/offset   per-component NEW params (mode 0=OFF, 1=NEW)
//   out_valid / out_ready     resolved params handshake
//   out_mode/type/aux/offset  resolved params, stable while out_valid
//   err_merge                 one-cycle pulse on an illegal merge (feature only)
// ---------------------------------------------------------------------------
module sao_param_resolve
   import sao_pkg::*;
(
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic [CTU_X_LEN-1:0]                        in_ctu_x,
   input  logic [CTU_Y_LEN-1:0]                        in_ctu_y,
   input  logic                                        in_merge_left,
   input  logic                                        in_merge_up,
   input  logic [N_COMP-1:0][MODE_LEN-1:0]             in_mode,
   input  logic [N_COMP-1:0][N_SAO_TYPE-1:0]           in_type,
   input  logic [N_COMP-1:0][AUX_LEN-1:0]              in_aux,
   input  logic [N_COMP-1:0][N_OFFSET-1:0][OFFSET_LEN-1:0] in_offset,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [N_COMP-1:0][MODE_LEN-1:0]             out_mode,
   output logic [N_COMP-1:0][N_SAO_TYPE-1:0]           out_type,
   output logic [N_COMP-1:0][AUX_LEN-1:0]              out_aux,
   output logic [N_COMP-1:0][N_OFFSET-1:0][OFFSET_LEN-1:0] out_offset,
   output logic                                        err_merge
);

   state_t                 state_reg;
   logic [1:0]             cnt_reg;
   logic [CTU_X_LEN-1:0]   ctu_x_reg;
   logic [CTU_Y_LEN-1:0]   ctu_y_reg;
   logic                   merge_left_reg;
   logic                   merge_up_reg;
   logic                   out_valid_reg;

   sao_param_t             in_param  [N_COMP];
   sao_param_t             in_reg    [N_COMP];
   sao_param_t             up_reg    [N_COMP];
   sao_param_t             left_reg  [N_COMP];
   sao_param_t             res_reg   [N_COMP];
   sao_param_t             res_next  [N_COMP];

   logic                   bad_merge;
   logic                   lb_en;
   logic                   lb_we;
   logic [AW-1:0]          lb_addr;
   logic [DW-1:0]          lb_wdata;
   logic [DW-1:0]          lb_rdata;

   // ------------------------------------------------------------------
   // Port <-> struct mapping
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < N_COMP; gi++) begin : g_comp
         assign in_param[gi] = '{mode:     in_mode[gi],
                                 sao_type: in_type[gi],
                                 aux:      in_aux[gi],
                                 offset:   in_offset[gi]};
         assign out_mode[gi]   = res_reg[gi].mode;
         assign out_type[gi]   = res_reg[gi].sao_type;
         assign out_aux[gi]    = res_reg[gi].aux;
         assign out_offset[gi] = res_reg[gi].offset;
      end
   endgenerate

   assign in_ready  = (state_reg == ST_IDLE);
   assign out_valid = out_valid_reg;

   // ------------------------------------------------------------------
   // Illegal-merge detection (optional)
   // ------------------------------------------------------------------
`ifdef SAO_MERGE_CHK_EN
   logic err_merge_reg;
   logic accept_illegal;

   assign bad_merge      = (merge_left_reg && (ctu_x_reg == '0)) ||
                           (merge_up_reg && !merge_left_reg && (ctu_y_reg == '0));
   assign accept_illegal = (in_merge_left && (in_ctu_x == '0)) ||
                           (in_merge_up && !in_merge_left && (in_ctu_y == '0));

   // Raised on the edge that enters RESOLVE so the pulse lines up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_merge_reg <= 1'b0;
      end else begin
         err_merge_reg <= ((state_reg == ST_IDLE) && in_valid &&
                           !(in_merge_up && !in_merge_left) && accept_illegal) ||
                          ((state_reg == ST_FETCH) && (cnt_reg == 2'd3) && bad_merge);
      end
   end

   assign err_merge = err_merge_reg;
`else
   logic ctu_y_unused;

   assign bad_merge    = 1'b0;
   assign err_merge    = 1'b0;
   assign ctu_y_unused = ^ctu_y_reg;
`endif

   // ------------------------------------------------------------------
   // Resolve mux: illegal merge -> OFF, merge_left beats merge_up,
   // NEW syntax with mode OFF clears everything else.
   // ------------------------------------------------------------------
   always_comb begin
      for (int c = 0; c < N_COMP; c++) begin
         res_next[c] = '0;
         if (bad_merge) begin
            res_next[c] = '0;
         end else if (merge_left_reg) begin
            res_next[c] = left_reg[c];
         end else if (merge_up_reg) begin
            res_next[c] = up_reg[c];
         end else if (in_reg[c].mode == SAO_MODE_NEW) begin
            res_next[c] = in_reg[c];
         end
      end
   end

   // ------------------------------------------------------------------
   // Line-buffer control: reads in FETCH slots 0..2, writes in WRITE 0..2.
   // cnt_reg doubles as the component index in both states.
   // ------------------------------------------------------------------
   always_comb begin
      lb_en    = 1'b0;
      lb_we    = 1'b0;
      lb_wdata = '0;
      if ((state_reg == ST_FETCH) && (cnt_reg != 2'd3)) begin
         lb_en = 1'b1;
      end
      if (state_reg == ST_WRITE) begin
         lb_en = 1'b1;
         lb_we = 1'b1;
      end
      for (int c = 0; c < N_COMP; c++) begin
         if (cnt_reg == 2'(c)) begin
            lb_wdata = sao_pack(res_reg[c]);
         end
      end
   end

   assign lb_addr = AW'(ctu_x_reg) + sao_comp_base(cnt_reg);

   sao_param_linebuf #(
      .DEPTH (N_COMP * MAX_CTU_COLS),
      .DW    (DW),
      .AW    (AW)
   ) u_linebuf (
      .clk   (clk),
      .en    (lb_en),
      .we    (lb_we),
      .addr  (lb_addr),
      .wdata (lb_wdata),
      .rdata (lb_rdata)
   );

   // ------------------------------------------------------------------
   // Control FSM with registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= '0;
         ctu_x_reg      <= '0;
         ctu_y_reg      <= '0;
         merge_left_reg <= 1'b0;
         merge_up_reg   <= 1'b0;
         out_valid_reg  <= 1'b0;
         for (int c = 0; c < N_COMP; c++) begin
            in_reg[c]   <= '0;
            up_reg[c]   <= '0;
            left_reg[c] <= '0;
            res_reg[c]  <= '0;
         end
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (in_valid) begin
                  ctu_x_reg      <= in_ctu_x;
                  ctu_y_reg      <= in_ctu_y;
                  merge_left_reg <= in_merge_left;
                  merge_up_reg   <= in_merge_up;
                  for (int c = 0; c < N_COMP; c++) begin
                     in_reg[c] <= in_param[c];
                  end
                  cnt_reg <= '0;
                  if (in_merge_up && !in_merge_left) begin
                     state_reg <= ST_FETCH;
                  end else begin
                     state_reg <= ST_RESOLVE;
                  end
               end
            end

            ST_FETCH: begin
               // Data read in slot k lands one cycle later, in slot k+1.
               for (int c = 0; c < N_COMP; c++) begin
                  if (cnt_reg == 2'(c + 1)) begin
                     up_reg[c] <= sao_unpack(lb_rdata);
                  end
               end
               cnt_reg <= cnt_reg + 2'd1;
               if (cnt_reg == 2'd3) begin
                  state_reg <= ST_RESOLVE;
               end
            end

            ST_RESOLVE: begin
               for (int c = 0; c < N_COMP; c++) begin
                  res_reg[c] <= res_next[c];
               end
               cnt_reg   <= '0;
               state_reg <= ST_WRITE;
            end

            ST_WRITE: begin
               for (int c = 0; c < N_COMP; c++) begin
                  if (cnt_reg == 2'(c)) begin
                     left_reg[c] <= res_reg[c];
                  end
               end
               cnt_reg <= cnt_reg + 2'd1;
               if (cnt_reg == 2'd2) begin
                  cnt_reg       <= '0;
                  out_valid_reg <= 1'b1;
                  state_reg     <= ST_OUT;
               end
            end

            ST_OUT: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= ST_IDLE;
               end
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sao_param_resolve.sv
// ---------------------------------------------------------------------------
// tb_sao_param_resolve
//  Directed bench for sao_param_resolve. A reference model of the left
//  registers and the line buffer produces the expected parameters of every
//  CTU, which are queued at accept time and popped when out_valid appears.
// ---------------------------------------------------------------------------
module tb_sao_param_resolve;
   import sao_pkg::*;

   typedef sao_param_t [N_COMP-1:0] ctu_params_t;

   typedef struct {
      ctu_params_t p;
      int          lat;
      int          nrd;
      int          nerr;
      int          x;
   } exp_item_t;

`ifdef SAO_MERGE_CHK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic                                            clk = 1'b0;
   logic                                            rst;
   logic                                            in_valid;
   logic                                            in_ready;
   logic [CTU_X_LEN-1:0]                            in_ctu_x;
   logic [CTU_Y_LEN-1:0]                            in_ctu_y;
   logic                                            in_merge_left;
   logic                                            in_merge_up;
   logic [N_COMP-1:0][MODE_LEN-1:0]                 in_mode;
   logic [N_COMP-1:0][N_SAO_TYPE-1:0]               in_type;
   logic [N_COMP-1:0][AUX_LEN-1:0]                  in_aux;
   logic [N_COMP-1:0][N_OFFSET-1:0][OFFSET_LEN-1:0] in_offset;
   logic                                            out_valid;
   logic                                            out_ready;
   logic [N_COMP-1:0][MODE_LEN-1:0]                 out_mode;
   logic [N_COMP-1:0][N_SAO_TYPE-1:0]               out_type;
   logic [N_COMP-1:0][AUX_LEN-1:0]                  out_aux;
   logic [N_COMP-1:0][N_OFFSET-1:0][OFFSET_LEN-1:0] out_offset;
   logic                                            err_merge;

   int          n_assert = 0;
   int          n_fail   = 0;
   exp_item_t   exp_q[$];
   int          rd_q[$];
   sao_param_t  left_m [N_COMP];
   sao_param_t  lb_m   [N_COMP][128];

   always #5 clk = ~clk;

   sao_param_resolve dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_ctu_x      (in_ctu_x),
      .in_ctu_y      (in_ctu_y),
      .in_merge_left (in_merge_left),
      .in_merge_up   (in_merge_up),
      .in_mode       (in_mode),
      .in_type       (in_type),
      .in_aux        (in_aux),
      .in_offset     (in_offset),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_mode      (out_mode),
      .out_type      (out_type),
      .out_aux       (out_aux),
      .out_offset    (out_offset),
      .err_merge     (err_merge)
   );

   // Line-buffer read observer (mid-cycle, combinational controls settled).
   always @(negedge clk) begin
      if (dut.lb_en === 1'b1 && dut.lb_we === 1'b0) begin
         rd_q.push_back(int'(dut.lb_addr));
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic sao_param_t mk(input int mode, input int typ, input int aux,
                                     input int o0, input int o1, input int o2, input int o3);
      sao_param_t r;
      r.mode      = 2'(mode);
      r.sao_type  = 3'(typ);
      r.aux       = 5'(aux);
      r.offset[0] = 4'(o0);
      r.offset[1] = 4'(o1);
      r.offset[2] = 4'(o2);
      r.offset[3] = 4'(o3);
      return r;
   endfunction

   function automatic ctu_params_t get_out();
      ctu_params_t r;
      for (int c = 0; c < N_COMP; c++) begin
         r[c] = sao_param_t'({out_mode[c], out_type[c], out_aux[c], out_offset[c]});
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_ctu(input int x, input int y, input bit ml, input bit mu,
                            input ctu_params_t p);
      in_ctu_x      = CTU_X_LEN'(x);
      in_ctu_y      = CTU_Y_LEN'(y);
      in_merge_left = ml;
      in_merge_up   = mu;
      for (int c = 0; c < N_COMP; c++) begin
         in_mode[c]   = p[c].mode;
         in_type[c]   = p[c].sao_type;
         in_aux[c]    = p[c].aux;
         in_offset[c] = p[c].offset;
      end
      in_valid = 1'b1;
   endtask

   task automatic wait_idle();
      int waited = 0;
      while (in_ready !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      check("in_ready_wait", in_ready, 1'b1);
   endtask

   // One CTU: model, drive, wait for output, compare, optional output stall.
   task automatic send(input int x, input int y, input bit ml, input bit mu,
                       input ctu_params_t p, input int stall);
      exp_item_t   it;
      ctu_params_t e;
      bit          illegal;
      int          lat;
      int          errs;
      string       tag;

      wait_idle();

      illegal = CHK_EN && ((ml && x == 0) || (mu && !ml && y == 0));
      for (int c = 0; c < N_COMP; c++) begin
         if (illegal)                     e[c] = '0;
         else if (ml)                     e[c] = left_m[c];
         else if (mu)                     e[c] = lb_m[c][x];
         else if (p[c].mode == SAO_MODE_NEW) e[c] = p[c];
         else                             e[c] = '0;
      end
      for (int c = 0; c < N_COMP; c++) begin
         left_m[c]   = e[c];
         lb_m[c][x]  = e[c];
      end
      it.p    = e;
      it.lat  = (mu && !ml) ? 9 : 5;
      it.nrd  = (mu && !ml) ? 3 : 0;
      it.nerr = illegal ? 1 : 0;
      it.x    = x;
      exp_q.push_back(it);

      rd_q.delete();
      drive_ctu(x, y, ml, mu, p);
      tick();
      in_valid      = 1'b0;
      in_merge_left = 1'b0;
      in_merge_up   = 1'b0;

      lat  = 1;
      errs = 0;
      while (out_valid !== 1'b1 && lat < 30) begin
         if (err_merge === 1'b1) errs++;
         tick();
         lat++;
      end

      it = exp_q.pop_front();
      $display("ctu (%0d,%0d) ml=%0d mu=%0d latency=%0d reads=%0d", x, y, ml, mu, lat, rd_q.size());
      check("latency", lat, it.lat);
      check("err_merge_pulses", errs, it.nerr);
      check("read_count", rd_q.size(), it.nrd);
      for (int k = 0; k < it.nrd; k++) begin
         if (k < rd_q.size()) begin
            check("read_addr", rd_q[k], it.x + k * MAX_CTU_COLS);
         end
      end
      for (int c = 0; c < N_COMP; c++) begin
         tag = $sformatf("out_param_c%0d", c);
         check(tag, get_out()[c], it.p[c]);
      end

      for (int s = 0; s < stall; s++) begin
         tick();
         check("stall_out_valid", out_valid, 1'b1);
         check("stall_in_ready", in_ready, 1'b0);
         check("stall_out_stable", get_out(), it.p);
      end

      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("post_accept_out_valid", out_valid, 1'b0);
      check("post_accept_in_ready", in_ready, 1'b1);
   endtask

   initial begin
      ctu_params_t p1, p2, p3, g;

      rst           = 1'b1;
      in_valid      = 1'b0;
      out_ready     = 1'b0;
      in_ctu_x      = '0;
      in_ctu_y      = '0;
      in_merge_left = 1'b0;
      in_merge_up   = 1'b0;
      in_mode       = '0;
      in_type       = '0;
      in_aux        = '0;
      in_offset     = '0;
      for (int c = 0; c < N_COMP; c++) begin
         left_m[c] = '0;
         for (int i = 0; i < 128; i++) lb_m[c][i] = '0;
      end

      p1[0] = mk(1, 2, 0, 1, 0, 0, -1);
      p1[1] = mk(1, 4, 12, 2, 1, -1, -2);
      p1[2] = mk(0, 3, 7, 5, 5, 5, 5);
      p2[0] = mk(1, 4, 31, -8, 7, -1, 1);
      p2[1] = mk(1, 1, 0, 3, 2, 1, 0);
      p2[2] = mk(1, 3, 0, -4, -3, -2, -1);
      p3[0] = mk(0, 2, 5, 6, 6, 6, 6);
      p3[1] = mk(1, 0, 0, 1, 1, 1, 1);
      p3[2] = mk(0, 0, 0, 0, 0, 0, 0);
      g[0]  = mk(1, 1, 3, 7, 7, 7, 7);
      g[1]  = mk(1, 1, 3, 7, 7, 7, 7);
      g[2]  = mk(1, 1, 3, 7, 7, 7, 7);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_err_merge", err_merge, 1'b0);
      check("reset_out_params", get_out(), '0);
      rst = 1'b0;
      tick();

      send(0, 0, 1'b0, 1'b0, p1, 0);   // NEW at (0,0)
      send(1, 0, 1'b1, 1'b0, g,  0);   // merge_left
      send(0, 1, 1'b0, 1'b1, g,  0);   // merge_up
      send(1, 1, 1'b0, 1'b0, p2, 7);   // NEW with 7-cycle backpressure
      send(2, 0, 1'b0, 1'b0, p3, 0);   // Y OFF with nonzero offsets
      send(2, 1, 1'b0, 1'b1, g,  2);   // merge_up of that CTU
      send(3, 1, 1'b1, 1'b1, g,  0);   // both merges: left wins
`ifdef SAO_MERGE_CHK_EN
      send(3, 0, 1'b0, 1'b1, g,  0);   // merge_up in top row
      send(0, 2, 1'b1, 1'b0, g,  0);   // merge_left in column 0
`endif

      // Reset in the middle of a fetch aborts the CTU.
      wait_idle();
      drive_ctu(2, 2, 1'b0, 1'b1, g);
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      $display("reset mid-fetch: out_valid=%0d in_ready=%0d", out_valid, in_ready);
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_in_ready", in_ready, 1'b1);
      rst = 1'b0;
      for (int c = 0; c < N_COMP; c++) left_m[c] = '0;
      tick();
      check("release_in_ready", in_ready, 1'b1);
      check("release_out_params", get_out(), '0);
      check("release_err_merge", err_merge, 1'b0);

      send(1, 2, 1'b1, 1'b0, g, 0);    // left regs cleared by reset
      send(0, 3, 1'b0, 1'b1, g, 0);    // line buffer survives reset
      send(2, 3, 1'b0, 1'b1, g, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
